nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 154 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial adder controller reusing one 4-bit prefix adder (optional subtract via ADD_CTRL_SUB_EN)

// 4-bit parallel-prefix adder: generate/propagate combined into group carries
module prefix_add4 (
    output logic       cout,
    output logic [3:0] sum,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic       g10, p10, g32, p32;

    // Prefix tree: pair-wise group terms, then carries from cin
    always_comb begin
        g   = a & b;
        p   = a ^ b;
        g10 = g[1] | (p[1] & g[0]);
        p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g10 | (p10 & cin);
        c[3] = g[2] | (p[2] & c[2]);
        c[4] = g32 | (p32 & g10) | (p32 & p10 & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef ADD_CTRL_SUB_EN
    input  logic                 op,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry_q;
    logic [W-1:0]   sum_q;
    logic           cout_q;
    logic           in_ready_q;
    logic           busy_q;
    logic           out_valid_q;

    logic [3:0]     add_sum;
    logic           add_cout;
    logic [W-1:0]   b_load;
    logic           c_load;

    // Operand conditioning at accept time: subtract becomes a + ~b + 1
    always_comb begin
`ifdef ADD_CTRL_SUB_EN
        b_load = op ? ~b : b;
        c_load = op ? 1'b1 : cin;
`else
        b_load = b;
        c_load = cin;
`endif
    end

    prefix_add4 u_add (
        .cout (add_cout),
        .sum  (add_sum),
        .a    (a_q[4*idx +: 4]),
        .b    (b_q[4*idx +: 4]),
        .cin  (carry_q)
    );

    // Control FSM: latch operands, step one nibble per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b_load;
                        carry_q    <= c_load;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[4*idx +: 4] <= add_sum;
                    carry_q           <= add_cout;
                    if (idx == LAST) begin
                        cout_q      <= add_cout;
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
`ifdef ADD_CTRL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_CTRL_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic on the (W+1)-bit result
    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic mop);
        logic [15:0] nb;
        nb = ~mb;
        if (SUB_EN && mop) return {1'b0, ma} + {1'b0, nb} + 17'd1;
        return {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
    endfunction

    // One transaction; inputs scrambled after accept; optional stall of 'hold' cycles
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic top, input logic [15:0] es, input logic ec,
                          input string nm, input int hold);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({nm, "_ready_wait"}, 32'(n < 50), 32'd1);
        a = ta; b = tb; cin = tc; op = top;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op = 1'($urandom);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        chk({nm, "_in_ready_run"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            a = 16'($urandom); b = 16'($urandom);
        end
        chk({nm, "_latency"}, 32'(lat), 32'(N + 1));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_hold_sum"}, 32'(sum), 32'(es));
            chk({nm, "_hold_cout"}, 32'(cout), 32'(ec));
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [16:0] r;
        logic [15:0] ra, rb;
        logic        rc, rop;
        int          acc [3];
        logic [15:0] pa [3];
        logic [15:0] pb [3];
        int          n;

        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
`ifdef ADD_CTRL_SUB_EN
        vecs.push_back('{16'h1234, 16'h1235, 1'b0, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back('{16'h1235, 16'h1234, 1'b0, 1'b1, 16'h0001, 1'b1});
        vecs.push_back('{16'h1235, 16'h1234, 1'b1, 1'b1, 16'h0001, 1'b1});
        vecs.push_back('{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);

        // Directed table
        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, vecs[i].es, vecs[i].ec,
                   $sformatf("vec%0d", i), 0);

        // Stall with output held and inputs toggling
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "hold", 10);

        // Random against model
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            rop = SUB_EN ? 1'($urandom) : 1'b0;
            r = model(ra, rb, rc, rop);
            run_op(ra, rb, rc, rop, r[15:0], r[16], $sformatf("rnd%0d", i),
                   int'($urandom_range(0, 3)));
        end

        // Reset two cycles after accept aborts the operation
        a = 16'hAAAA; b = 16'h1111; cin = 1'b1; op = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        n = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) n++;
            @(negedge clk);
        end
        chk("abort_no_out_valid", 32'(n), 32'd0);

        // Back-to-back with in_valid and out_ready held high
        pa[0] = 16'h1111; pb[0] = 16'h2222;
        pa[1] = 16'hFFFF; pb[1] = 16'h0002;
        pa[2] = 16'h0F0F; pb[2] = 16'h00F1;
        out_ready = 1'b1;
        cin = 1'b0; op = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (!in_ready && n < 50) begin @(negedge clk); n++; end
            chk("b2b_ready_wait", 32'(n < 50), 32'd1);
            a = pa[p]; b = pb[p];
            in_valid = 1'b1;
            acc[p] = cyc;
            @(negedge clk);
            n = 0;
            while (!out_valid && n < 20) begin @(negedge clk); n++; end
            r = model(pa[p], pb[p], 1'b0, 1'b0);
            chk($sformatf("b2b%0d_sum", p), 32'(sum), 32'(r[15:0]));
            chk($sformatf("b2b%0d_cout", p), 32'(cout), 32'(r[16]));
            @(negedge clk);
            if (p > 0) chk($sformatf("b2b%0d_spacing", p), 32'(acc[p] - acc[p-1]), 32'(N + 2));
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
